// File: rtl/retire_trace_unit_pkg.sv
// Shared types and entry layout for the retirement trace unit.
// Entry layout from MSB: {kind, inum, pc, reg_idx, value, addr}.
package trace_pkg;

  typedef enum logic [2:0] {
    KIND_REG   = 3'd0,
    KIND_LOAD  = 3'd1,
    KIND_STORE = 3'd2,
    KIND_NOP   = 3'd3,
    KIND_HALT  = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int KIND_W   = 3;
  localparam int ADDR_OFF = 0;

  function automatic int entryWidth(input int inumW, input int addrW, input int regW,
                                    input int dataW);
    return KIND_W + inumW + addrW + regW + dataW + addrW;
  endfunction

  // Field offsets are measured from bit 0 of the packed entry.
  function automatic int valueOff(input int addrW);
    return addrW;
  endfunction

  function automatic int regOff(input int addrW, input int dataW);
    return addrW + dataW;
  endfunction

  function automatic int pcOff(input int addrW, input int dataW, input int regW);
    return addrW + dataW + regW;
  endfunction

  function automatic int inumOff(input int addrW, input int dataW, input int regW);
    return 2 * addrW + dataW + regW;
  endfunction

  function automatic int kindOff(input int addrW, input int dataW, input int regW,
                                 input int inumW);
    return 2 * addrW + dataW + regW + inumW;
  endfunction

endpackage

// File: rtl/retire_trace_unit_if.sv
// Retire-event bus from the core plus the trace output stream.
// master = core/consumer side, slave = the trace unit.
interface retire_trace_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int INUM_W = 16
);
  localparam int ENTRY_W = trace_pkg::entryWidth(INUM_W, ADDR_W, REG_W, DATA_W);

  logic              ev_valid;
  logic [ADDR_W-1:0] ev_pc;
  logic              ev_reg_write;
  logic [REG_W-1:0]  ev_reg_idx;
  logic [DATA_W-1:0] ev_wdata;
  logic              ev_mem_read;
  logic              ev_mem_write;
  logic [ADDR_W-1:0] ev_mem_addr;
  logic [DATA_W-1:0] ev_mem_data;
  logic              ev_halt;

  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_entry;

  modport master (
    output ev_valid, ev_pc, ev_reg_write, ev_reg_idx, ev_wdata,
           ev_mem_read, ev_mem_write, ev_mem_addr, ev_mem_data, ev_halt,
           out_ready,
    input  out_valid, out_entry
  );

  modport slave (
    input  ev_valid, ev_pc, ev_reg_write, ev_reg_idx, ev_wdata,
           ev_mem_read, ev_mem_write, ev_mem_addr, ev_mem_data, ev_halt,
           out_ready,
    output out_valid, out_entry
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered head: a word pushed at edge N is visible after N.
// Push while full is accepted only when a pop happens at the same edge.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtrReg;
  logic [PW-1:0]    rdPtrReg;
  logic [CW-1:0]    countReg;
  logic [WIDTH-1:0] headReg;
  logic [WIDTH-1:0] headNext;
  logic [PW-1:0]    rdPtrNext;
  logic [CW-1:0]    remaining;
  logic             popFire;
  logic             pushFire;

  assign empty    = (countReg == '0);
  assign full     = (countReg == CW'(DEPTH));
  assign count    = countReg;
  assign head     = headReg;
  assign popFire  = pop & ~empty;
  assign pushFire = push & (~full | popFire);

  assign rdPtrNext = rdPtrReg + PW'(popFire);
  assign remaining = countReg - CW'(popFire);

  // Next head: the incoming word when nothing else is left, else the next stored word.
  always_comb begin
    headNext = '0;
    if (remaining == '0) begin
      if (pushFire) begin
        headNext = pushData;
      end
    end else begin
      headNext = mem[rdPtrNext];
    end
  end

  always_ff @(posedge clk) begin
    if (pushFire) begin
      mem[wrPtrReg] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      headReg  <= '0;
    end else if (clear) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      headReg  <= '0;
    end else begin
      wrPtrReg <= wrPtrReg + PW'(pushFire);
      rdPtrReg <= rdPtrNext;
      countReg <= countReg + CW'(pushFire) - CW'(popFire);
      headReg  <= headNext;
    end
  end
endmodule

// File: rtl/retire_trace_unit.sv
// Retirement trace capture: classifies retire events, queues them, keeps counters.
// Optional watchdog enabled by defining TRACE_WATCHDOG_EN.
module retire_trace_unit
  import trace_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  parameter int INUM_W = 16
`ifdef TRACE_WATCHDOG_EN
  , parameter int WDOG_LIMIT = 100000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               cap_en,
  retire_trace_unit_if.slave bus,
  output logic [CNT_W-1:0]   inst_count,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   ovf_count,
  output logic               ovf_flag,
  output logic [1:0]         state,
  output logic               done
`ifdef TRACE_WATCHDOG_EN
  , output logic             wdog_timeout
`endif
);
  localparam int ENTRY_W   = entryWidth(INUM_W, ADDR_W, REG_W, DATA_W);
  localparam int VALUE_OFF = valueOff(ADDR_W);
  localparam int REG_OFF   = regOff(ADDR_W, DATA_W);
  localparam int PC_OFF    = pcOff(ADDR_W, DATA_W, REG_W);
  localparam int INUM_OFF  = inumOff(ADDR_W, DATA_W, REG_W);
  localparam int KIND_OFF  = kindOff(ADDR_W, DATA_W, REG_W, INUM_W);
  localparam int FCW       = $clog2(DEPTH) + 1;

  state_e             stateReg;
  logic [CNT_W-1:0]   instCountReg;
  logic [CNT_W-1:0]   cycleCountReg;
  logic [CNT_W-1:0]   ovfCountReg;
  logic               ovfFlagReg;
  logic               doneReg;

  logic               capturing;
  logic               captureAbort;
  logic               pushReq;
  logic               pushFire;
  logic               popFire;
  logic               drop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               fifoClear;
  logic [FCW-1:0]     fifoCount;
  logic [ENTRY_W-1:0] fifoHead;

  kind_e              kind;
  logic [REG_W-1:0]   regIdx;
  logic [DATA_W-1:0]  value;
  logic [ADDR_W-1:0]  addr;
  logic [ENTRY_W-1:0] pushEntry;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign capturing = (stateReg == ST_CAPTURE);

`ifdef TRACE_WATCHDOG_EN
  logic wdogReg;

  // Fires on the edge that brings cycle_count to the limit.
  assign captureAbort = capturing && !(bus.ev_valid && bus.ev_halt)
                        && (cycleCountReg == CNT_W'(WDOG_LIMIT - 1));
  assign wdog_timeout = wdogReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdogReg <= 1'b0;
    end else if (clear) begin
      wdogReg <= 1'b0;
    end else if (captureAbort) begin
      wdogReg <= 1'b1;
    end
  end
`else
  assign captureAbort = 1'b0;
`endif

  assign fifoClear = clear | captureAbort;
  assign pushReq   = capturing & bus.ev_valid & ~captureAbort;
  assign popFire   = bus.out_ready & ~fifoEmpty;
  assign drop      = pushReq & fifoFull & ~popFire;
  assign pushFire  = pushReq & ~drop;

  always_comb begin
    kind   = KIND_NOP;
    regIdx = '0;
    value  = '0;
    addr   = '0;
    if (bus.ev_reg_write && bus.ev_mem_read) begin
      kind   = KIND_LOAD;
      regIdx = bus.ev_reg_idx;
      value  = bus.ev_wdata;
      addr   = bus.ev_mem_addr;
    end else if (bus.ev_reg_write) begin
      kind   = KIND_REG;
      regIdx = bus.ev_reg_idx;
      value  = bus.ev_wdata;
    end else if (bus.ev_halt) begin
      kind   = KIND_HALT;
    end else if (bus.ev_mem_write) begin
      kind   = KIND_STORE;
      value  = bus.ev_mem_data;
      addr   = bus.ev_mem_addr;
    end
  end

  always_comb begin
    pushEntry = '0;
    pushEntry[KIND_OFF +: KIND_W]  = kind;
    pushEntry[INUM_OFF +: INUM_W]  = instCountReg[INUM_W-1:0];
    pushEntry[PC_OFF +: ADDR_W]    = bus.ev_pc;
    pushEntry[REG_OFF +: REG_W]    = regIdx;
    pushEntry[VALUE_OFF +: DATA_W] = value;
    pushEntry[ADDR_OFF +: ADDR_W]  = addr;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (fifoClear),
    .push     (pushReq),
    .pushData (pushEntry),
    .pop      (bus.out_ready),
    .head     (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign bus.out_valid = ~fifoEmpty;
  assign bus.out_entry = fifoHead;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg      <= ST_IDLE;
      doneReg       <= 1'b0;
      instCountReg  <= '0;
      cycleCountReg <= '0;
      ovfCountReg   <= '0;
      ovfFlagReg    <= 1'b0;
    end else if (clear) begin
      stateReg      <= ST_IDLE;
      doneReg       <= 1'b0;
      instCountReg  <= '0;
      cycleCountReg <= '0;
      ovfCountReg   <= '0;
      ovfFlagReg    <= 1'b0;
    end else begin
      if (pushFire) begin
        instCountReg <= satInc(instCountReg);
      end
      if (drop) begin
        ovfCountReg <= satInc(ovfCountReg);
        ovfFlagReg  <= 1'b1;
      end
      if (capturing) begin
        cycleCountReg <= satInc(cycleCountReg);
      end

      case (stateReg)
        ST_IDLE: begin
          if (cap_en) begin
            stateReg <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // A halt moves to DRAIN even when its entry was dropped.
          if (captureAbort) begin
            stateReg <= ST_DONE;
            doneReg  <= 1'b1;
          end else if (bus.ev_valid && bus.ev_halt) begin
            stateReg <= ST_DRAIN;
          end else if (!cap_en) begin
            stateReg <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (fifoEmpty || (popFire && fifoCount == FCW'(1))) begin
            stateReg <= ST_DONE;
            doneReg  <= 1'b1;
          end
        end
        default: begin
          stateReg <= ST_DONE;
        end
      endcase
    end
  end

  assign inst_count  = instCountReg;
  assign cycle_count = cycleCountReg;
  assign ovf_count   = ovfCountReg;
  assign ovf_flag    = ovfFlagReg;
  assign state       = stateReg;
  assign done        = doneReg;
endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed bench for retire_trace_unit; watchdog cases build when TRACE_WATCHDOG_EN is defined.
module tb_retire_trace_unit;
  localparam int ENTRY_W = 71;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        cap_en = 1'b0;
  logic [31:0] inst_count;
  logic [31:0] cycle_count;
  logic [31:0] ovf_count;
  logic        ovf_flag;
  logic [1:0]  state;
  logic        done;
`ifdef TRACE_WATCHDOG_EN
  logic        wdog_timeout;
`endif

  int checkCount = 0;
  int passCount  = 0;

  retire_trace_unit_if #(.ADDR_W(16), .DATA_W(16), .REG_W(4), .INUM_W(16)) bus ();

  retire_trace_unit #(
    .ADDR_W (16),
    .DATA_W (16),
    .REG_W  (4),
    .DEPTH  (16),
    .CNT_W  (32),
    .INUM_W (16)
`ifdef TRACE_WATCHDOG_EN
    , .WDOG_LIMIT (50)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .cap_en      (cap_en),
    .bus         (bus.slave),
    .inst_count  (inst_count),
    .cycle_count (cycle_count),
    .ovf_count   (ovf_count),
    .ovf_flag    (ovf_flag),
    .state       (state),
    .done        (done)
`ifdef TRACE_WATCHDOG_EN
    , .wdog_timeout (wdog_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleEv();
    bus.ev_valid     = 1'b0;
    bus.ev_pc        = '0;
    bus.ev_reg_write = 1'b0;
    bus.ev_reg_idx   = '0;
    bus.ev_wdata     = '0;
    bus.ev_mem_read  = 1'b0;
    bus.ev_mem_write = 1'b0;
    bus.ev_mem_addr  = '0;
    bus.ev_mem_data  = '0;
    bus.ev_halt      = 1'b0;
  endtask

  task automatic setEv(input logic rw, input logic mr, input logic mw, input logic hl,
                       input logic [15:0] pc, input logic [3:0] ri, input logic [15:0] wd,
                       input logic [15:0] ma, input logic [15:0] md);
    bus.ev_valid     = 1'b1;
    bus.ev_pc        = pc;
    bus.ev_reg_write = rw;
    bus.ev_reg_idx   = ri;
    bus.ev_wdata     = wd;
    bus.ev_mem_read  = mr;
    bus.ev_mem_write = mw;
    bus.ev_mem_addr  = ma;
    bus.ev_mem_data  = md;
    bus.ev_halt      = hl;
  endtask

  function automatic logic [ENTRY_W-1:0] mkEntry(input logic [2:0] k, input logic [15:0] inum,
                                                 input logic [15:0] pc, input logic [3:0] r,
                                                 input logic [15:0] v, input logic [15:0] a);
    return {k, inum, pc, r, v, a};
  endfunction

  task automatic expectHead(input string tag, input logic [ENTRY_W-1:0] exp);
    $display("head %s: valid=%0b entry=0x%0h", tag, bus.out_valid, bus.out_entry);
    checkEq({tag, " valid"}, bus.out_valid, 1'b1);
    checkEq(tag, bus.out_entry, exp);
  endtask

  initial begin
    idleEv();
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkEq("rst out_valid", bus.out_valid, 1'b0);
    checkEq("rst out_entry", bus.out_entry, '0);
    checkEq("rst inst", inst_count, 32'd0);
    checkEq("rst cycle", cycle_count, 32'd0);
    checkEq("rst ovf", ovf_count, 32'd0);
    checkEq("rst ovf_flag", ovf_flag, 1'b0);
    checkEq("rst state", state, 2'd0);
    checkEq("rst done", done, 1'b0);
    rst = 1'b0;

    // Basic classification with consumer always ready
    cap_en = 1'b1;
    tick();
    checkEq("capture entered", state, 2'd1);
    bus.out_ready = 1'b1;
    setEv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd3, 16'h00AA, 16'h0000, 16'h0000);
    tick();
    expectHead("reg ev", mkEntry(3'd0, 16'd0, 16'h0000, 4'd3, 16'h00AA, 16'h0000));
    setEv(1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 4'd4, 16'h1234, 16'h0010, 16'h0000);
    tick();
    expectHead("load ev", mkEntry(3'd1, 16'd1, 16'h0002, 4'd4, 16'h1234, 16'h0010));
    setEv(1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 4'd7, 16'hBEEF, 16'h0020, 16'h5555);
    tick();
    expectHead("store ev", mkEntry(3'd2, 16'd2, 16'h0004, 4'd0, 16'h5555, 16'h0020));
    idleEv();
    tick();
    checkEq("basic drained", bus.out_valid, 1'b0);
    checkEq("basic inst", inst_count, 32'd3);
    checkEq("basic cycle", cycle_count, 32'd4);

    // Clear returns to reset values
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkEq("clear inst", inst_count, 32'd0);
    checkEq("clear cycle", cycle_count, 32'd0);
    checkEq("clear state", state, 2'd0);
    tick();
    checkEq("recapture", state, 2'd1);

    // Overflow: 20 NOP events, consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      setEv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(2 * i), 4'd5, 16'h0077, 16'h0000, 16'h0000);
      tick();
    end
    checkEq("ovf inst", inst_count, 32'd16);
    checkEq("ovf count", ovf_count, 32'd4);
    checkEq("ovf flag", ovf_flag, 1'b1);
    expectHead("ovf head stable", mkEntry(3'd3, 16'd0, 16'h0100, 4'd0, 16'h0000, 16'h0000));

    // Full FIFO with simultaneous push and pop
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expectHead("full pushpop", mkEntry(3'd3, 16'(k), 16'h0100 + 16'(2 * k), 4'd0, 16'h0000, 16'h0000));
      setEv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(2 * (16 + k)), 4'd0, 16'h0000, 16'h0000, 16'h0000);
      tick();
    end
    idleEv();
    checkEq("pushpop inst", inst_count, 32'd21);
    checkEq("pushpop ovf", ovf_count, 32'd4);
    for (int i = 5; i <= 20; i++) begin
      expectHead("drain", mkEntry(3'd3, 16'(i), 16'h0100 + 16'(2 * i), 4'd0, 16'h0000, 16'h0000));
      tick();
    end
    checkEq("drain empty", bus.out_valid, 1'b0);

    // cap_en dropped for 10 cycles
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    repeat (3) tick();
    cap_en = 1'b0;
    tick();
    checkEq("pause state", state, 2'd0);
    setEv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 4'd6, 16'h6666, 16'h0000, 16'h0000);
    repeat (10) tick();
    checkEq("pause cycle", cycle_count, 32'd4);
    checkEq("pause inst", inst_count, 32'd0);
    checkEq("pause ovf", ovf_count, 32'd0);
    checkEq("pause ovf_flag", ovf_flag, 1'b0);
    checkEq("pause empty", bus.out_valid, 1'b0);
    idleEv();
    cap_en = 1'b1;
    tick();
    checkEq("resume state", state, 2'd1);

    // Halt with two entries queued
    bus.out_ready = 1'b0;
    setEv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 4'd1, 16'h1111, 16'h0000, 16'h0000);
    tick();
    setEv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0032, 4'd2, 16'h2222, 16'h0000, 16'h0000);
    tick();
    setEv(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 4'd0, 16'h0000, 16'h0044, 16'h9999);
    tick();
    checkEq("halt drain", state, 2'd2);
    setEv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 4'd5, 16'h5050, 16'h0000, 16'h0000);
    repeat (2) tick();
    checkEq("drain inst frozen", inst_count, 32'd3);
    checkEq("drain no ovf", ovf_count, 32'd0);
    checkEq("drain cycle frozen", cycle_count, 32'd7);
    idleEv();
    bus.out_ready = 1'b1;
    expectHead("halt q0", mkEntry(3'd0, 16'd0, 16'h0030, 4'd1, 16'h1111, 16'h0000));
    tick();
    expectHead("halt q1", mkEntry(3'd0, 16'd1, 16'h0032, 4'd2, 16'h2222, 16'h0000));
    tick();
    expectHead("halt entry", mkEntry(3'd4, 16'd2, 16'h0040, 4'd0, 16'h0000, 16'h0000));
    checkEq("still drain", state, 2'd2);
    tick();
    checkEq("done state", state, 2'd3);
    checkEq("done flag", done, 1'b1);
    checkEq("done empty", bus.out_valid, 1'b0);
    tick();
    checkEq("done holds", state, 2'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkEq("clear after done", state, 2'd0);
    checkEq("clear done flag", done, 1'b0);

`ifdef TRACE_WATCHDOG_EN
    // Watchdog: no halt, consumer stalled
    begin
      int n;
      tick();
      bus.out_ready = 1'b0;
      setEv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0200, 4'd0, 16'h0000, 16'h0000, 16'h0000);
      n = 0;
      while (state != 2'd3 && n < 200) begin
        tick();
        n++;
      end
      idleEv();
      checkEq("wdog edges", 32'(n), 32'd50);
      checkEq("wdog cycle", cycle_count, 32'd50);
      checkEq("wdog timeout", wdog_timeout, 1'b1);
      checkEq("wdog flushed", bus.out_valid, 1'b0);
      checkEq("wdog done", done, 1'b1);
      checkEq("wdog inst", inst_count, 32'd16);
      checkEq("wdog ovf", ovf_count, 32'd33);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkEq("wdog cleared", wdog_timeout, 1'b0);
    end
`endif

    // Asynchronous reset mid-run
    tick();
    bus.out_ready = 1'b0;
    setEv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0070, 4'd7, 16'h7777, 16'h0000, 16'h0000);
    repeat (2) tick();
    idleEv();
    checkEq("pre-rst valid", bus.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkEq("arst out_valid", bus.out_valid, 1'b0);
    checkEq("arst out_entry", bus.out_entry, '0);
    checkEq("arst inst", inst_count, 32'd0);
    checkEq("arst cycle", cycle_count, 32'd0);
    checkEq("arst state", state, 2'd0);
    #2;
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/retire_trace_unit.md
Name: retire_trace_unit

Overview:
- Synthesizable, parametrised retirement-trace capture block; moves the per-instruction REG/LOAD/STORE/NOP/HALT trace classification from simulation-only logging into hardware.
- Sits beside the cpu core and samples one retire event per cycle (PC, writeback, memory, halt).
- Each event is classified, tagged with an instruction number, and buffered in a FIFO drained over a valid/ready port.
- Also keeps instruction, cycle and overflow counters and a capture/drain/done state machine for pipelined-core bring-up and on-board debug.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, width of register/memory data
REG_W, 4, register index width
DEPTH, 16, FIFO entries (power of 2, >=2)
CNT_W, 32, width of inst/cycle/overflow counters
INUM_W, 16, instruction-number field stored per entry (low bits of inst counter)
WDOG_LIMIT, 100000, cycle limit for optional watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear: FIFO, counters, flags -> reset values, state IDLE
cap_en  in  1  capture enable (level)
ev_valid  in  1  one instruction retires this cycle
ev_pc  in  ADDR_W  PC of retiring instruction
ev_reg_write  in  1  register writeback
ev_reg_idx  in  REG_W  destination register
ev_wdata  in  DATA_W  writeback data
ev_mem_read  in  1  load
ev_mem_write  in  1  store
ev_mem_addr  in  ADDR_W  memory address
ev_mem_data  in  DATA_W  store data
ev_halt  in  1  halt retiring
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_entry  out  ENTRY_W  head entry {kind[2:0], inum, pc, reg_idx, value, addr}
inst_count  out  CNT_W  events accepted into FIFO
cycle_count  out  CNT_W  cycles spent in CAPTURE
ovf_count  out  CNT_W  events dropped because FIFO full
ovf_flag  out  1  sticky, set on first drop
state  out  2  IDLE=0, CAPTURE=1, DRAIN=2, DONE=3
done  out  1  state==DONE

Behaviour:
- Reset (rst=1, async): FIFO empty, all counters 0, ovf_flag=0, state IDLE, out_valid=0, out_entry=0, done=0.
- `clear` is synchronous and has the same effect. It has priority over every other input except rst.
- IDLE -> CAPTURE when cap_en=1. CAPTURE -> IDLE when cap_en=0; counters and FIFO hold.
- CAPTURE -> DRAIN on a cycle with ev_valid & ev_halt.
- DRAIN -> DONE in the cycle the FIFO becomes empty; DRAIN with an already-empty FIFO goes to DONE on the next edge.
- DONE holds until clear or rst.
- Events are sampled only in CAPTURE. In IDLE, DRAIN and DONE, events are ignored and not counted as overflow.
- Classification priority, first match wins:
  - reg_write & mem_read -> LOAD(1): value=wdata, addr=mem_addr.
  - reg_write -> REG(0): value=wdata, addr=0.
  - halt -> HALT(4): value=0, addr=0.
  - mem_write -> STORE(2): value=mem_data, addr=mem_addr, reg_idx=0.
  - otherwise NOP(3): value/addr/reg_idx=0.
  - kind codes 5-7 are reserved.
- inum = inst_count[INUM_W-1:0] before increment (0-based); it wraps modulo 2^INUM_W.
- Push when capturing & ev_valid & (not full, or pop in the same cycle). Accepted events increment inst_count.
- Full FIFO and no pop: entry dropped, ovf_count+1, ovf_flag=1, inst_count unchanged.
- A dropped halt still causes CAPTURE -> DRAIN.
- FIFO has no fall-through: an event accepted at edge N is visible on out_valid/out_entry after edge N.
- Pop at an edge with out_valid & out_ready. Simultaneous push and pop on a full FIFO succeeds with the count unchanged.
- out_entry holds stable while out_valid & !out_ready.
- cycle_count +1 every cycle in CAPTURE.
- All counters saturate at all-ones and do not wrap.

Optional Feature:
- TRACE_WATCHDOG_EN defined:
  - In CAPTURE, reaching cycle_count == WDOG_LIMIT with no halt forces state DONE, discarding the FIFO contents (out_valid=0).
  - Output port wdog_timeout (1 bit, sticky, cleared by rst/clear) is asserted.
- Undefined: no watchdog logic and no wdog_timeout port; capture runs indefinitely.

Decomposition:
- Package trace_pkg:
  - kind enum (REG, LOAD, STORE, NOP, HALT).
  - state enum.
  - ENTRY_W computed as 3+INUM_W+ADDR_W+REG_W+DATA_W+ADDR_W.
  - entry field-offset constants.
- One sub-module: trace_fifo, a parametrised synchronous FIFO with DEPTH/WIDTH parameters, full/empty flags and registered output.
- Classification, counters and FSM stay in retire_trace_unit.

Test Plan:
- Reset then cap_en=1; 3 events: reg_write r3=0x00AA @PC 0x0000; load r4=0x1234 addr 0x0010 @PC 0x0002; store 0x5555->0x0020 @PC 0x0004; out_ready=1 -> entries kind 0,1,2, inum 0,1,2, inst_count=3.
- out_ready=0, DEPTH=16, push 20 events -> 16 stored, ovf_count=4, ovf_flag=1; then drain -> first inum 0, last inum 15.
- Full FIFO plus simultaneous push/pop for 5 cycles -> no drops, count stays 16, inums continue 16..20.
- Halt @PC 0x0040 with 2 entries queued -> state DRAIN, post-halt events ignored (inst_count frozen); after 2 pops and the HALT pop -> DONE, done=1.
- cap_en toggled 0 for 10 cycles mid-run -> cycle_count frozen, events dropped without ovf; clear -> all counters 0, IDLE.
- TRACE_WATCHDOG_EN, WDOG_LIMIT=50, no halt -> DONE at cycle_count=50, wdog_timeout=1, out_valid=0; async rst pulse mid-run -> outputs at reset values immediately.
